// File: rtl/padding_reader.sv
// Streams a frame out of an upstream row FIFO, adding an optional one-word
// zero border, with row-level flow control from both the FIFO and downstream.
module padding_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pad_en,
    input  logic [ADDR_BITS:0]   col_num,
    input  logic [ADDR_BITS:0]   row_num,
    output logic [ADDR_BITS:0]   M_count,
    input  logic                 M_Ready,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 S_Ready,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 dout_eol,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned AW = ADDR_BITS + 1;
    localparam int unsigned CW = ADDR_BITS + 2;

    typedef enum logic [2:0] {
        IDLE,
        ROW_WAIT,
        ROW_EMIT,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic            pad_q;
    logic [AW-1:0]   col_lim;
    logic [CW-1:0]   cols_out;
    logic [CW-1:0]   rows_out;
    logic [CW-1:0]   col;
    logic [CW-1:0]   row;
    logic [1:0]      wait_cnt;
    logic            drain_cnt;
    logic            p1_valid;
    logic            p1_pad;
    logic            p1_eol;

    logic            row_pad;
    logic            last_col;
    logic            last_row;
    logic [CW-1:0]   col_nx;
    logic            rd_first;
    logic            rd_nx;

    // Whether column k of the current row consumes a FIFO word.
    function automatic logic rd_for(input logic [CW-1:0] k, input logic rp,
                                    input logic pe, input logic [AW-1:0] n);
        if (rp)
            return 1'b0;
        if (pe)
            return (k != '0) && (k <= CW'(n));
        return k < CW'(n);
    endfunction

    always_comb begin
        row_pad  = pad_q && ((row == '0) || (row == rows_out - CW'(1)));
        last_col = (col == cols_out - CW'(1));
        last_row = (row == rows_out - CW'(1));
        col_nx   = col + CW'(1);
        rd_first = rd_for('0, row_pad, pad_q, col_lim);
        rd_nx    = rd_for(col_nx, row_pad, pad_q, col_lim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pad_q      <= 1'b0;
            col_lim    <= '0;
            cols_out   <= '0;
            rows_out   <= '0;
            col        <= '0;
            row        <= '0;
            wait_cnt   <= '0;
            drain_cnt  <= 1'b0;
            p1_valid   <= 1'b0;
            p1_pad     <= 1'b0;
            p1_eol     <= 1'b0;
            M_count    <= '0;
            fifo_rd_en <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_eol   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            p1_valid   <= 1'b0;
            p1_pad     <= 1'b0;
            p1_eol     <= 1'b0;
            fifo_rd_en <= 1'b0;
            done       <= 1'b0;

            // Second stage: FIFO data for a slot arrives while its flags sit in stage one.
            dout_valid <= p1_valid;
            dout_eol   <= p1_eol;
            dout       <= (p1_valid && !p1_pad) ? fifo_dout : '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        pad_q    <= pad_en;
                        col_lim  <= col_num;
                        M_count  <= col_num;
                        cols_out <= CW'(col_num) + (pad_en ? CW'(2) : CW'(0));
                        rows_out <= CW'(row_num) + (pad_en ? CW'(2) : CW'(0));
                        col      <= '0;
                        row      <= '0;
                        wait_cnt <= '0;
                        busy     <= 1'b1;
                        if ((col_num == '0) || (row_num == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ROW_WAIT;
                        end
                    end
                end

                ROW_WAIT: begin
                    // Ready flags lag by a cycle; skip the first two before trusting them.
                    if (wait_cnt < 2'd2) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else if (S_Ready && (row_pad || M_Ready)) begin
                        state      <= ROW_EMIT;
                        col        <= '0;
                        fifo_rd_en <= rd_first;
                    end
                end

                ROW_EMIT: begin
                    p1_valid <= 1'b1;
                    p1_pad   <= !fifo_rd_en;
                    p1_eol   <= last_col;
                    if (!last_col) begin
                        col        <= col_nx;
                        fifo_rd_en <= rd_nx;
                    end else if (last_row) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        row      <= row + CW'(1);
                        wait_cnt <= '0;
                        state    <= ROW_WAIT;
                    end
                end

                DRAIN: begin
                    if (drain_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_padding_reader.sv
// Directed bench for padding_reader with a simple FIFO model and output monitor.
module tb_padding_reader;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned ADDR_BITS = 10;
    localparam int unsigned AW        = ADDR_BITS + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             pad_en;
    logic [AW-1:0]    col_num;
    logic [AW-1:0]    row_num;
    logic [AW-1:0]    M_count;
    logic             M_Ready;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             S_Ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_eol;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [7:0] words[$];
    bit         eols[$];
    int         rd_cnt   = 0;
    int         done_cnt = 0;
    int         rd_idx   = 0;
    int         w0, r0, d0, i0;

    localparam logic [7:0] BASE = 8'h10;

    padding_reader #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .pad_en(pad_en),
        .col_num(col_num), .row_num(row_num), .M_count(M_count),
        .M_Ready(M_Ready), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .S_Ready(S_Ready), .dout(dout), .dout_valid(dout_valid),
        .dout_eol(dout_eol), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= BASE + 8'(rd_idx);
            rd_idx    <= rd_idx + 1;
        end
    end

    always @(negedge clk) begin
        if (dout_valid) begin
            words.push_back(dout);
            eols.push_back(dout_eol);
        end
        if (fifo_rd_en) rd_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mark();
        w0 = words.size();
        r0 = rd_cnt;
        d0 = done_cnt;
        i0 = rd_idx;
    endtask

    task automatic launch(input logic pe, input int c, input int r);
        pad_en  = pe;
        col_num = AW'(c);
        row_num = AW'(r);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s done_timeout got no done within %0d cycles", name, n);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        checks++; if (M_count !== '0)      begin errors++; $display("FAIL reset_mcount got %0d exp 0", M_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nopad();
        mark();
        M_Ready = 1'b1;
        S_Ready = 1'b1;
        launch(1'b0, 4, 2);
        checks++; if (M_count !== AW'(4)) begin errors++; $display("FAIL nopad_mcount got %0d exp 4", M_count); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL nopad_busy got %b exp 1", busy); end
        wait_done("nopad");
        checks++; if (rd_cnt - r0 != 8)         begin errors++; $display("FAIL nopad_reads got %0d exp 8", rd_cnt - r0); end
        checks++; if (words.size() - w0 != 8)   begin errors++; $display("FAIL nopad_words got %0d exp 8", words.size() - w0); end
        for (int i = 0; i < 8 && i < words.size() - w0; i++) begin
            checks++;
            if (words[w0+i] !== BASE + 8'(i0 + i)) begin
                errors++; $display("FAIL nopad_data[%0d] got %h exp %h", i, words[w0+i], BASE + 8'(i0 + i));
            end
            checks++;
            if (eols[w0+i] !== (i == 3 || i == 7)) begin
                errors++; $display("FAIL nopad_eol[%0d] got %b exp %b", i, eols[w0+i], (i == 3 || i == 7));
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL nopad_done_count got %0d exp 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL nopad_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_pad();
        logic [7:0] exp_w[$];
        bit         exp_e[$];
        int         d;
        mark();
        d = i0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) begin
                if (r == 0 || r == 3 || k == 0 || k == 4) exp_w.push_back(8'h00);
                else begin exp_w.push_back(BASE + 8'(d)); d++; end
                exp_e.push_back(k == 4);
            end
        end
        launch(1'b1, 3, 2);
        wait_done("pad");
        checks++; if (rd_cnt - r0 != 6)        begin errors++; $display("FAIL pad_reads got %0d exp 6", rd_cnt - r0); end
        checks++; if (words.size() - w0 != 20) begin errors++; $display("FAIL pad_words got %0d exp 20", words.size() - w0); end
        for (int i = 0; i < 20 && i < words.size() - w0; i++) begin
            checks++;
            if (words[w0+i] !== exp_w[i]) begin
                errors++; $display("FAIL pad_data[%0d] got %h exp %h", i, words[w0+i], exp_w[i]);
            end
            checks++;
            if (eols[w0+i] !== exp_e[i]) begin
                errors++; $display("FAIL pad_eol[%0d] got %b exp %b", i, eols[w0+i], exp_e[i]);
            end
        end
    endtask

    task automatic test_mready_stall();
        int n = 0;
        mark();
        M_Ready = 1'b0;
        S_Ready = 1'b1;
        launch(1'b0, 2, 1);
        repeat (10) tick();
        checks++; if (rd_cnt != r0)        begin errors++; $display("FAIL stall_reads got %0d exp 0", rd_cnt - r0); end
        checks++; if (words.size() != w0)  begin errors++; $display("FAIL stall_words got %0d exp 0", words.size() - w0); end
        M_Ready = 1'b1;
        while (!fifo_rd_en && n < 4) begin
            tick();
            n++;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL stall_resume_latency got %0d exp 1", n); end
        wait_done("stall");
        checks++; if (words.size() - w0 != 2) begin errors++; $display("FAIL stall_total got %0d exp 2", words.size() - w0); end
        if (words.size() - w0 >= 2) begin
            checks++;
            if (words[w0+1] !== BASE + 8'(i0 + 1)) begin
                errors++; $display("FAIL stall_data got %h exp %h", words[w0+1], BASE + 8'(i0 + 1));
            end
        end
    endtask

    task automatic test_sready_pad();
        mark();
        M_Ready = 1'b1;
        S_Ready = 1'b0;
        launch(1'b1, 1, 1);
        repeat (8) tick();
        checks++; if (words.size() != w0) begin errors++; $display("FAIL padhold_words got %0d exp 0", words.size() - w0); end
        checks++; if (rd_cnt != r0)       begin errors++; $display("FAIL padhold_reads got %0d exp 0", rd_cnt - r0); end
        S_Ready = 1'b1;
        wait_done("padhold");
        checks++; if (words.size() - w0 != 9) begin errors++; $display("FAIL padhold_total got %0d exp 9", words.size() - w0); end
        checks++; if (rd_cnt - r0 != 1)       begin errors++; $display("FAIL padhold_reads_total got %0d exp 1", rd_cnt - r0); end
        for (int i = 0; i < 9 && i < words.size() - w0; i++) begin
            checks++;
            if (words[w0+i] !== ((i == 4) ? BASE + 8'(i0) : 8'h00)) begin
                errors++; $display("FAIL padhold_data[%0d] got %h exp %h", i, words[w0+i], (i == 4) ? BASE + 8'(i0) : 8'h00);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        mark();
        M_Ready = 1'b1;
        S_Ready = 1'b1;
        launch(1'b0, 4, 2);
        while (rd_cnt - r0 < 6 && n < 100) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL abort_rd_en got %b exp 0", fifo_rd_en); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", dout_valid); end
        checks++; if (dout_eol !== 1'b0)   begin errors++; $display("FAIL abort_eol got %b exp 0", dout_eol); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (dout !== 8'h00)      begin errors++; $display("FAIL abort_dout got %h exp 00", dout); end
        checks++; if (M_count !== '0)      begin errors++; $display("FAIL abort_mcount got %0d exp 0", M_count); end
        rst = 1'b0;
        mark();
        repeat (8) tick();
        checks++; if (rd_cnt != r0)       begin errors++; $display("FAIL abort_late_reads got %0d exp 0", rd_cnt - r0); end
        checks++; if (words.size() != w0) begin errors++; $display("FAIL abort_late_words got %0d exp 0", words.size() - w0); end
        checks++; if (done_cnt != d0)     begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt - d0); end
        mark();
        launch(1'b0, 2, 2);
        wait_done("after_abort");
        checks++; if (words.size() - w0 != 4) begin errors++; $display("FAIL clean_words got %0d exp 4", words.size() - w0); end
        if (words.size() - w0 >= 4) begin
            checks++;
            if (words[w0+3] !== BASE + 8'(i0 + 3)) begin
                errors++; $display("FAIL clean_data got %h exp %h", words[w0+3], BASE + 8'(i0 + 3));
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL clean_done got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_start_busy_zero();
        mark();
        M_Ready = 1'b1;
        S_Ready = 1'b1;
        launch(1'b0, 2, 1);
        tick();
        col_num = AW'(3);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checks++; if (M_count !== AW'(2)) begin errors++; $display("FAIL busy_start_mcount got %0d exp 2", M_count); end
        wait_done("busy_start");
        checks++; if (words.size() - w0 != 2) begin errors++; $display("FAIL busy_start_words got %0d exp 2", words.size() - w0); end
        checks++; if (done_cnt - d0 != 1)     begin errors++; $display("FAIL busy_start_done got %0d exp 1", done_cnt - d0); end
        mark();
        launch(1'b0, 0, 3);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b exp 1", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clear got %b exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_clear got %b exp 0", busy); end
        repeat (3) tick();
        checks++; if (rd_cnt != r0)       begin errors++; $display("FAIL zero_reads got %0d exp 0", rd_cnt - r0); end
        checks++; if (words.size() != w0) begin errors++; $display("FAIL zero_words got %0d exp 0", words.size() - w0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pad_en  = 1'b0;
        col_num = '0;
        row_num = '0;
        M_Ready = 1'b0;
        S_Ready = 1'b0;
        test_reset();
        test_nopad();
        test_pad();
        test_mready_stall();
        test_sready_pad();
        test_reset_mid();
        test_start_busy_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
